risc8_fetch: RTL and testbench

Instruction fetch unit for the RISC-8 core. It streams 16-bit words from the synchronous program ROM into a small prefetch buffer and presents complete instructions to the instruction decoder with a valid/ready handshake. For LDS, STS, JMP and CALL it presents both words together. It discards all buffered and in-flight words when the core redirects the PC.

---
 rtl/risc8_fetch_pkg.sv | 17 +
 rtl/risc8_fetch_if.sv | 26 ++
 rtl/risc8_fetch_fifo.sv | 64 ++++++
 rtl/risc8_fetch.sv | 67 ++++++
 tb/tb_risc8_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/risc8_fetch_pkg.sv
// risc8_fetch_pkg: shared RISC-8 instruction classes and two-word opcode detection
package risc8_fetch_pkg;

    localparam logic [9:0] LDS_STS_MATCH  = 10'b100100_0000;
    localparam logic [8:0] JMP_CALL_MATCH = 9'b1001010_11;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    function automatic logic two_word(input logic [15:0] op);
        return {op[15:10], op[3:0]} == LDS_STS_MATCH || {op[15:9], op[3:2]} == JMP_CALL_MATCH;
    endfunction

endpackage

// File: rtl/risc8_fetch_if.sv
// risc8_fetch_if: program ROM port, decoder handshake and PC redirect bundle
interface risc8_fetch_if #(
    parameter int PC_BITS = 14
);
    logic [PC_BITS-1:0] pmem_addr;
    logic               pmem_re;
    logic [15:0]        pmem_data;
    logic               op_valid;
    logic               op_ready;
    logic [15:0]        opcode;
    logic [15:0]        opcode2;
    logic [PC_BITS-1:0] op_pc;
    logic               op_len2;
    logic               jump_valid;
    logic [PC_BITS-1:0] jump_addr;

    modport master (
        output pmem_addr, pmem_re, op_valid, opcode, opcode2, op_pc, op_len2,
        input  pmem_data, op_ready, jump_valid, jump_addr
    );

    modport slave (
        input  pmem_addr, pmem_re, op_valid, opcode, opcode2, op_pc, op_len2,
        output pmem_data, op_ready, jump_valid, jump_addr
    );
endinterface

// File: rtl/risc8_fetch_fifo.sv
// risc8_fetch_fifo: shift-style {word,pc} prefetch buffer, pop 0/1/2 and push 0/1 per cycle
module risc8_fetch_fifo
    import risc8_fetch_pkg::*;
#(
    parameter int PC_BITS = 14,
    parameter int DEPTH   = 3,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [15:0]        push_word,
    input  logic [PC_BITS-1:0] push_pc,
    input  pop_e               pop,
    output logic [CW-1:0]      count,
    output logic [15:0]        head_word,
    output logic [PC_BITS-1:0] head_pc,
    output logic [15:0]        next_word
);
    logic [15:0]        word_q [DEPTH];
    logic [PC_BITS-1:0] pc_q   [DEPTH];
    logic [15:0]        word_x [DEPTH+2];
    logic [PC_BITS-1:0] pc_x   [DEPTH+2];
    logic [15:0]        word_d [DEPTH];
    logic [PC_BITS-1:0] pc_d   [DEPTH];
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      wr_idx;

    assign wr_idx     = count_q - CW'(pop);
    assign word_x[DEPTH]   = '0;
    assign word_x[DEPTH+1] = '0;
    assign pc_x[DEPTH]     = '0;
    assign pc_x[DEPTH+1]   = '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign word_x[i] = word_q[i];
        assign pc_x[i]   = pc_q[i];
        assign word_d[i] = (push && wr_idx == CW'(i)) ? push_word :
                           pop == POP_TWO ? word_x[i+2] : pop == POP_ONE ? word_x[i+1] : word_x[i];
        assign pc_d[i]   = (push && wr_idx == CW'(i)) ? push_pc :
                           pop == POP_TWO ? pc_x[i+2] : pop == POP_ONE ? pc_x[i+1] : pc_x[i];
    end

    // Shift out popped entries and append the captured word behind the survivors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            word_q  <= '{default: '0};
            pc_q    <= '{default: '0};
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q - CW'(pop) + CW'(push);
            word_q  <= word_d;
            pc_q    <= pc_d;
        end
    end

    assign count     = count_q;
    assign head_word = word_q[0];
    assign head_pc   = pc_q[0];
    assign next_word = word_q[1];
endmodule

// File: rtl/risc8_fetch.sv
// risc8_fetch: ROM prefetch with two-word instruction assembly and redirect squash
module risc8_fetch
    import risc8_fetch_pkg::*;
#(
    parameter int PC_BITS = 14,
    parameter int DEPTH   = 3
) (
    input logic            clk,
    input logic            reset,
    risc8_fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_BITS-1:0] fetch_pc;
    logic [PC_BITS-1:0] rd_pc;
    logic               inflight;
    logic [CW-1:0]      count;
    logic [15:0]        head_word;
    logic [15:0]        next_word;
    logic [PC_BITS-1:0] head_pc;
    logic               len2;
    logic               accept;
    pop_e               pop;

    assign len2          = two_word(head_word);
    assign bus.op_valid  = count != '0 && (!len2 || count >= CW'(2));
    assign accept        = bus.op_valid && bus.op_ready && !bus.jump_valid;
    assign pop           = !accept ? POP_NONE : len2 ? POP_TWO : POP_ONE;
    assign bus.pmem_re   = !reset && (bus.jump_valid || int'(count) + int'(inflight) - int'(pop) < DEPTH);
    assign bus.pmem_addr = bus.jump_valid ? bus.jump_addr : fetch_pc;
    assign bus.opcode    = head_word;
    assign bus.opcode2   = len2 ? next_word : '0;
    assign bus.op_pc     = head_pc;
    assign bus.op_len2   = len2;

    // Advance the fetch pointer on every issued read; a redirect read replaces any outstanding one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= '0;
            rd_pc    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= bus.pmem_re;
            if (bus.pmem_re) begin
                fetch_pc <= bus.pmem_addr + PC_BITS'(1);
                rd_pc    <= bus.pmem_addr;
            end
        end
    end

    risc8_fetch_fifo #(
        .PC_BITS (PC_BITS),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.jump_valid),
        .push      (inflight),
        .push_word (bus.pmem_data),
        .push_pc   (rd_pc),
        .pop       (pop),
        .count     (count),
        .head_word (head_word),
        .head_pc   (head_pc),
        .next_word (next_word)
    );
endmodule

// File: tb/tb_risc8_fetch.sv
// tb_risc8_fetch: directed checks of fetch timing, two-word assembly, backpressure, redirect, wrap and reset
module tb_risc8_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset4 = 1'b1;
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int snap = 0;
    logic [13:0] hs_pc = '0;
    logic [15:0] rom [16384];
    logic [15:0] rom4 [16];

    always #5 clk = ~clk;

    risc8_fetch_if #(.PC_BITS(14)) bus ();
    risc8_fetch_if #(.PC_BITS(4))  bus4 ();

    risc8_fetch #(.PC_BITS(14), .DEPTH(3)) dut (.clk(clk), .reset(reset), .bus(bus));
    risc8_fetch #(.PC_BITS(4), .DEPTH(3)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    // Synchronous program ROMs: data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.pmem_re) bus.pmem_data <= rom[bus.pmem_addr];
        if (bus4.pmem_re) bus4.pmem_data <= rom4[bus4.pmem_addr];
    end

    // Record completed handshakes on the main instance
    always @(posedge clk) begin
        if (!reset && bus.op_valid && bus.op_ready && !bus.jump_valid) begin
            hs_cnt <= hs_cnt + 1;
            hs_pc  <= bus.op_pc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 16'(32'h1000 | (i & 32'h0FFF));
        for (int i = 0; i < 8; i++) rom[i] = 16'h0C01;
        rom[4] = 16'h940C;
        rom[5] = 16'h0123;
        for (int i = 0; i < 16; i++) rom4[i] = 16'(32'h0C00 | i);
        rom4[0]  = 16'h5A5A;
        rom4[15] = 16'h9200;
        bus.op_ready = 1'b0;
        bus.jump_valid = 1'b0;
        bus.jump_addr = '0;
        bus4.op_ready = 1'b0;
        bus4.jump_valid = 1'b0;
        bus4.jump_addr = '0;
        #2;
        chk("rst_valid", 32'(bus.op_valid), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        chk("rst_opcode2", 32'(bus.opcode2), 0);
        chk("rst_pc", 32'(bus.op_pc), 0);
        chk("rst_len2", 32'(bus.op_len2), 0);
        chk("rst_re", 32'(bus.pmem_re), 0);
        // cycle R: reset released, read address 0
        @(negedge clk);
        reset = 1'b0;
        bus.op_ready = 1'b1;
        #1;
        chk("r_re", 32'(bus.pmem_re), 1);
        chk("r_addr", 32'(bus.pmem_addr), 0);
        chk("r_valid", 32'(bus.op_valid), 0);
        @(negedge clk); #1;
        chk("r1_valid", 32'(bus.op_valid), 0);
        chk("r1_addr", 32'(bus.pmem_addr), 1);
        @(negedge clk); #1;
        chk("r2_valid", 32'(bus.op_valid), 1);
        chk("r2_pc", 32'(bus.op_pc), 0);
        chk("r2_opcode", 32'(bus.opcode), 32'h0C01);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1;
            chk("seq_valid", 32'(bus.op_valid), 1);
            chk("seq_pc", 32'(bus.op_pc), 32'(k));
        end
        // two-word JMP at 4 waits for its second word
        @(negedge clk); #1;
        chk("jmp_wait", 32'(bus.op_valid), 0);
        @(negedge clk); #1;
        chk("jmp_valid", 32'(bus.op_valid), 1);
        chk("jmp_opcode", 32'(bus.opcode), 32'h940C);
        chk("jmp_opcode2", 32'(bus.opcode2), 32'h0123);
        chk("jmp_len2", 32'(bus.op_len2), 1);
        chk("jmp_pc", 32'(bus.op_pc), 4);
        @(negedge clk); #1;
        chk("after_jmp_pc", 32'(bus.op_pc), 6);
        chk("after_jmp_len2", 32'(bus.op_len2), 0);
        chk("after_jmp_op2", 32'(bus.opcode2), 0);
        chk("hs_count5", 32'(hs_cnt), 5);
        chk("hs_pc4", 32'(hs_pc), 4);
        @(negedge clk); #1;
        chk("pc7", 32'(bus.op_pc), 7);
        @(negedge clk); #1;
        chk("pc8", 32'(bus.op_pc), 8);
        chk("pc8_opcode", 32'(bus.opcode), 32'h1008);
        // backpressure for 10 cycles
        bus.op_ready = 1'b0;
        @(negedge clk); #1;
        chk("bp_re_stop", 32'(bus.pmem_re), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk("bp_re", 32'(bus.pmem_re), 0);
            chk("bp_hold_pc", 32'(bus.op_pc), 8);
            chk("bp_valid", 32'(bus.op_valid), 1);
        end
        @(negedge clk);
        bus.op_ready = 1'b1;
        #1;
        chk("rel_pc", 32'(bus.op_pc), 8);
        chk("rel_re", 32'(bus.pmem_re), 1);
        chk("rel_addr", 32'(bus.pmem_addr), 11);
        for (int k = 9; k < 14; k++) begin
            @(negedge clk); #1;
            chk("rel_valid", 32'(bus.op_valid), 1);
            chk("rel_seq_pc", 32'(bus.op_pc), 32'(k));
        end
        // redirect while a read is outstanding
        @(negedge clk);
        bus.jump_valid = 1'b1;
        bus.jump_addr = 14'h0100;
        #1;
        snap = hs_cnt;
        chk("jv_re", 32'(bus.pmem_re), 1);
        chk("jv_addr", 32'(bus.pmem_addr), 32'h0100);
        @(negedge clk);
        bus.jump_valid = 1'b0;
        #1;
        chk("jv_no_hs", 32'(hs_cnt), 32'(snap));
        chk("jv_n1_valid", 32'(bus.op_valid), 0);
        chk("jv_n1_addr", 32'(bus.pmem_addr), 32'h0101);
        @(negedge clk); #1;
        chk("jv_n2_valid", 32'(bus.op_valid), 1);
        chk("jv_n2_pc", 32'(bus.op_pc), 32'h0100);
        chk("jv_n2_opcode", 32'(bus.opcode), 32'h1100);
        @(negedge clk); #1;
        chk("jv_hs_pc", 32'(hs_pc), 32'h0100);
        chk("jv_hs_cnt", 32'(hs_cnt), 32'(snap + 1));
        chk("jv_next_pc", 32'(bus.op_pc), 32'h0101);
        // fill the buffer, then reset mid-cycle
        bus.op_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("full_valid", 32'(bus.op_valid), 1);
        chk("full_re", 32'(bus.pmem_re), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.op_valid), 0);
        chk("async_re", 32'(bus.pmem_re), 0);
        chk("async_opcode", 32'(bus.opcode), 0);
        @(negedge clk);
        reset = 1'b0;
        bus.op_ready = 1'b1;
        #1;
        chk("rst2_re", 32'(bus.pmem_re), 1);
        chk("rst2_addr", 32'(bus.pmem_addr), 0);
        @(negedge clk); #1;
        chk("rst2_r1_valid", 32'(bus.op_valid), 0);
        @(negedge clk); #1;
        chk("rst2_r2_valid", 32'(bus.op_valid), 1);
        chk("rst2_pc", 32'(bus.op_pc), 0);
        // wrap: STS at 15 with PC_BITS=4 takes its second word from address 0
        @(negedge clk);
        reset4 = 1'b0;
        bus4.jump_valid = 1'b1;
        bus4.jump_addr = 4'd15;
        #1;
        chk("wrap_re", 32'(bus4.pmem_re), 1);
        chk("wrap_addr15", 32'(bus4.pmem_addr), 15);
        @(negedge clk);
        bus4.jump_valid = 1'b0;
        #1;
        chk("wrap_addr0", 32'(bus4.pmem_addr), 0);
        chk("wrap_n1_valid", 32'(bus4.op_valid), 0);
        @(negedge clk); #1;
        chk("wrap_n2_valid", 32'(bus4.op_valid), 0);
        @(negedge clk); #1;
        chk("wrap_n3_valid", 32'(bus4.op_valid), 1);
        chk("wrap_pc", 32'(bus4.op_pc), 15);
        chk("wrap_opcode", 32'(bus4.opcode), 32'h9200);
        chk("wrap_opcode2", 32'(bus4.opcode2), 32'h5A5A);
        chk("wrap_len2", 32'(bus4.op_len2), 1);
        bus4.op_ready = 1'b1;
        @(negedge clk); #1;
        chk("wrap_next_pc", 32'(bus4.op_pc), 1);
        chk("wrap_next_opcode", 32'(bus4.opcode), 32'h0C01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
